// File: rtl/msx_vdp_pkg.sv
// Shared VDP definitions: sprite FSM states, attribute layout and colour indices.
// Also provides the sprite height helper used by the scanner and the pixel slots.
package msx_vdp_pkg;

    typedef enum logic [2:0] {
        SPR_IDLE,
        SPR_SCAN,
        SPR_ATTR,
        SPR_PAT,
        SPR_LOAD
    } spr_state_e;

    localparam logic [7:0] SPR_TERMINATOR  = 8'hD0;
    localparam logic [7:0] SPR_NAME16_MASK = 8'hFC;

    localparam logic [1:0] SPR_OFF_Y     = 2'd0;
    localparam logic [1:0] SPR_OFF_X     = 2'd1;
    localparam logic [1:0] SPR_OFF_NAME  = 2'd2;
    localparam logic [1:0] SPR_OFF_COLOR = 2'd3;

    localparam logic [3:0] COLOR_TRANSPARENT = 4'h0;
    localparam logic [3:0] COLOR_BLACK       = 4'h1;
    localparam logic [3:0] COLOR_WHITE       = 4'hF;

    function automatic logic [5:0] spr_height(input logic size16, input logic mag);
        logic [5:0] h;
        h = 6'd8;
        if (size16) h = h << 1;
        if (mag)    h = h << 1;
        return h;
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One active sprite for the current line: position, colour and 16-bit pattern,
// resolved against the live pixel x into an opaque flag.
module sprite_slot
    import msx_vdp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        load_valid,
    input  logic [9:0]  load_x,
    input  logic [3:0]  load_color,
    input  logic [15:0] load_pat,
    input  logic [7:0]  pix_x,
    input  logic        mag,
    input  logic        size16,
    output logic        opaque,
    output logic [3:0]  color
);

    logic        valid_q;
    logic [9:0]  x_q;
    logic [15:0] pat_q;
    logic [9:0]  dx;
    logic [3:0]  col;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            color   <= COLOR_TRANSPARENT;
            pat_q   <= '0;
        end else if (load) begin
            valid_q <= load_valid;
            x_q     <= load_x;
            color   <= load_color;
            pat_q   <= load_pat;
        end
    end

    // x_q is 10-bit two's complement so early-clocked sprites can start left of 0
    always_comb begin
        dx     = {2'b00, pix_x} - x_q;
        col    = mag ? dx[4:1] : dx[3:0];
        opaque = valid_q && !dx[9]
                 && (dx < {4'b0000, spr_height(size16, mag)})
                 && pat_q[4'd15 - col];
    end

endmodule

// File: rtl/sprite_engine.sv
// Per-scanline sprite processor: scans the attribute table in hblank, fetches
// attributes and patterns for visible sprites, then drives prioritised pixels.
module sprite_engine
    import msx_vdp_pkg::*;
#(
    parameter int MAX_SPRITES = 4,
    parameter int NUM_SPRITES = 32,
    parameter int ADDR_W      = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [7:0]        line_y,
    input  logic [ADDR_W-1:0] sprite_attr_addr,
    input  logic [ADDR_W-1:0] sprite_pattern_table_addr,
    input  logic              size16,
    input  logic              mag,
    output logic [ADDR_W-1:0] vid_addr,
    input  logic [7:0]        vid_out,
    output logic              busy,
    input  logic [7:0]        pix_x,
    input  logic              pix_en,
    output logic [3:0]        spr_color,
    output logic              fifth_flag,
    output logic [4:0]        fifth_num,
    output logic              collision,
    input  logic              status_clear
);

    localparam int IW = 5;
    localparam int CW = $clog2(MAX_SPRITES + 1);
    localparam int SW = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;

    spr_state_e state, state_n;

    logic [7:0]    line_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] sl, cnt;
    logic [1:0]    fld;
    logic          ph;

    logic [IW-1:0] sh_num   [MAX_SPRITES];
    logic [7:0]    sh_row   [MAX_SPRITES];
    logic [7:0]    sh_x     [MAX_SPRITES];
    logic [7:0]    sh_name  [MAX_SPRITES];
    logic [3:0]    sh_color [MAX_SPRITES];
    logic          sh_ec    [MAX_SPRITES];
    logic [15:0]   sh_pat   [MAX_SPRITES];

    logic [SW-1:0] cur;
    logic [7:0]    scan_row, pat_row;
    logic          scan_hit, scan_term, scan_full, scan_done;
    logic          attr_last, pat_slot_done;
    logic [1:0]    attr_off;

    logic [MAX_SPRITES-1:0] slot_opaque;
    logic [3:0]             slot_color [MAX_SPRITES];
    logic [3:0]             win_color;
    logic                   multi_opaque;

    always_comb begin
        cur           = sl[SW-1:0];
        scan_row      = line_q - vid_out - 8'd1;
        scan_hit      = scan_row < {2'b00, spr_height(size16, mag)};
        scan_term     = vid_out == SPR_TERMINATOR;
        scan_full     = cnt == CW'(MAX_SPRITES);
        scan_done     = scan_term || (scan_hit && scan_full) || (idx == IW'(NUM_SPRITES - 1));
        attr_last     = (sl + CW'(1)) == cnt;
        pat_slot_done = fld[0] || !size16;
        attr_off      = fld + 2'd1;
        pat_row       = mag ? {1'b0, sh_row[cur][7:1]} : sh_row[cur];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= SPR_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (line_start) begin
            state_n = SPR_SCAN;
        end else begin
            case (state)
                SPR_SCAN: if (ph && scan_done) state_n = SPR_ATTR;
                SPR_ATTR: begin
                    if (!ph && sl == cnt)                      state_n = SPR_LOAD;
                    else if (ph && fld == 2'd2 && attr_last)   state_n = SPR_PAT;
                end
                SPR_PAT:  if (ph && pat_slot_done && attr_last) state_n = SPR_LOAD;
                SPR_LOAD: state_n = SPR_IDLE;
                default:  ;
            endcase
        end
    end

    always_comb begin
        vid_addr = '0;
        case (state)
            SPR_SCAN: vid_addr = sprite_attr_addr + ADDR_W'({idx, 2'b00}) + ADDR_W'(SPR_OFF_Y);
            SPR_ATTR: vid_addr = sprite_attr_addr + ADDR_W'({sh_num[cur], 2'b00}) + ADDR_W'(attr_off);
            SPR_PAT:  vid_addr = sprite_pattern_table_addr + ADDR_W'({sh_name[cur], 3'b000})
                                 + ADDR_W'(pat_row) + (fld[0] ? ADDR_W'(16) : '0);
            default:  ;
        endcase
    end

    assign busy = state != SPR_IDLE;

    // ph=0 presents the address, ph=1 captures vid_out for it
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q     <= '0;
            idx        <= '0;
            sl         <= '0;
            cnt        <= '0;
            fld        <= '0;
            ph         <= 1'b0;
            fifth_flag <= 1'b0;
            fifth_num  <= '0;
        end else begin
            if (status_clear) begin
                fifth_flag <= 1'b0;
                fifth_num  <= '0;
            end
            if (line_start) begin
                line_q <= line_y;
                idx    <= '0;
                sl     <= '0;
                cnt    <= '0;
                fld    <= '0;
                ph     <= 1'b0;
            end else begin
                case (state)
                    SPR_SCAN: begin
                        ph <= ~ph;
                        if (ph) begin
                            if (!scan_term && scan_hit) begin
                                if (scan_full) begin
                                    if (!fifth_flag || status_clear) begin
                                        fifth_flag <= 1'b1;
                                        fifth_num  <= idx;
                                    end
                                end else begin
                                    sh_num[cnt[SW-1:0]] <= idx;
                                    sh_row[cnt[SW-1:0]] <= scan_row;
                                    cnt                 <= cnt + CW'(1);
                                end
                            end
                            idx <= idx + IW'(1);
                        end
                    end
                    SPR_ATTR: begin
                        if (!ph) begin
                            if (sl != cnt) ph <= 1'b1;
                        end else begin
                            ph <= 1'b0;
                            case (fld)
                                2'd0:    sh_x[cur]    <= vid_out;
                                2'd1:    sh_name[cur] <= size16 ? (vid_out & SPR_NAME16_MASK) : vid_out;
                                default: begin
                                    sh_color[cur] <= vid_out[3:0];
                                    sh_ec[cur]    <= vid_out[7];
                                end
                            endcase
                            if (fld == 2'd2) begin
                                fld <= '0;
                                sl  <= attr_last ? '0 : sl + CW'(1);
                            end else begin
                                fld <= fld + 2'd1;
                            end
                        end
                    end
                    SPR_PAT: begin
                        if (!ph) begin
                            ph <= 1'b1;
                        end else begin
                            ph <= 1'b0;
                            if (!fld[0]) sh_pat[cur]      <= {vid_out, 8'h00};
                            else         sh_pat[cur][7:0] <= vid_out;
                            if (pat_slot_done) begin
                                fld <= '0;
                                sl  <= sl + CW'(1);
                            end else begin
                                fld <= 2'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < MAX_SPRITES; g++) begin : g_slot
        sprite_slot u_slot (
            .clk        (clk),
            .reset      (reset),
            .load       (state == SPR_LOAD),
            .load_valid (CW'(g) < cnt),
            .load_x     ({2'b00, sh_x[g]} - (sh_ec[g] ? 10'd32 : 10'd0)),
            .load_color (sh_color[g]),
            .load_pat   (sh_pat[g]),
            .pix_x      (pix_x),
            .mag        (mag),
            .size16     (size16),
            .opaque     (slot_opaque[g]),
            .color      (slot_color[g])
        );
    end

    // colour-0 sprites are skipped for display but still counted for collision
    always_comb begin
        logic any;
        logic found;
        win_color    = COLOR_TRANSPARENT;
        multi_opaque = 1'b0;
        any          = 1'b0;
        found        = 1'b0;
        for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
            if (slot_opaque[i]) begin
                if (any) multi_opaque = 1'b1;
                any = 1'b1;
                if (!found && slot_color[i] != COLOR_TRANSPARENT) begin
                    win_color = slot_color[i];
                    found     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spr_color <= COLOR_TRANSPARENT;
            collision <= 1'b0;
        end else begin
            spr_color <= pix_en ? win_color : COLOR_TRANSPARENT;
            if (status_clear)           collision <= 1'b0;
            if (pix_en && multi_opaque) collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine with a behavioural VRAM and hand-computed
// expected pixels, status flags and busy durations.
module tb_sprite_engine;

    localparam int ATTR = 14'h1B00;
    localparam int PAT  = 14'h3800;

    logic        clk = 1'b0;
    logic        reset, line_start, size16, mag, pix_en, status_clear;
    logic [7:0]  line_y, pix_x, vid_out;
    logic [13:0] vid_addr;
    logic        busy, fifth_flag, collision;
    logic [4:0]  fifth_num;
    logic [3:0]  spr_color;
    logic [7:0]  vram [0:16383];

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [3:0] c;

    always #5 clk = ~clk;

    always_ff @(posedge clk) vid_out <= vram[vid_addr];

    sprite_engine #(.MAX_SPRITES(4), .NUM_SPRITES(32), .ADDR_W(14)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .line_start                (line_start),
        .line_y                    (line_y),
        .sprite_attr_addr          (14'(ATTR)),
        .sprite_pattern_table_addr (14'(PAT)),
        .size16                    (size16),
        .mag                       (mag),
        .vid_addr                  (vid_addr),
        .vid_out                   (vid_out),
        .busy                      (busy),
        .pix_x                     (pix_x),
        .pix_en                    (pix_en),
        .spr_color                 (spr_color),
        .fifth_flag                (fifth_flag),
        .fifth_num                 (fifth_num),
        .collision                 (collision),
        .status_clear              (status_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_sprite(input int n, input logic [7:0] y, input logic [7:0] x,
                              input logic [7:0] name, input logic [7:0] attr);
        vram[ATTR + 4*n]     = y;
        vram[ATTR + 4*n + 1] = x;
        vram[ATTR + 4*n + 2] = name;
        vram[ATTR + 4*n + 3] = attr;
    endtask

    task automatic run_line(input logic [7:0] y, output int cycles);
        line_y     = y;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        cycles = 0;
        while (busy && cycles < 300) begin
            cycles++;
            step();
        end
    endtask

    task automatic pixel(input logic [7:0] x, output logic [3:0] col);
        pix_x  = x;
        pix_en = 1'b1;
        step();
        col = spr_color;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        reset = 1'b1; line_start = 1'b0; line_y = 8'd0; size16 = 1'b0; mag = 1'b0;
        pix_en = 1'b0; pix_x = 8'd0; status_clear = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        check("reset_vid_addr", 32'(vid_addr), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_color", 32'(spr_color), 0);
        check("reset_fifth_flag", 32'(fifth_flag), 0);
        check("reset_fifth_num", 32'(fifth_num), 0);
        check("reset_collision", 32'(collision), 0);

        // single 8x8 sprite
        vram[PAT] = 8'hFF;
        put_sprite(0, 8'd9, 8'd20, 8'd0, 8'h04);
        put_sprite(1, 8'hD0, 8'd0, 8'd0, 8'h00);
        run_line(8'd10, cyc);
        check("t1_busy_within_20", 32'(cyc >= 1 && cyc <= 20), 1);
        for (int x = 19; x <= 28; x++) begin
            pixel(8'(x), c);
            check($sformatf("t1_pix_%0d", x), 32'(c), (x >= 20 && x <= 27) ? 4 : 0);
        end
        pix_en = 1'b0; pix_x = 8'd22;
        step();
        check("t1_pix_en_low", 32'(spr_color), 0);

        // terminator at entry 0 hides everything after it
        put_sprite(0, 8'hD0, 8'd0, 8'd0, 8'h00);
        put_sprite(1, 8'd9, 8'd20, 8'd0, 8'h04);
        run_line(8'd10, cyc);
        check("t2_busy_cycles", 32'(cyc), 4);
        pixel(8'd20, c); check("t2_pix_20", 32'(c), 0);
        pixel(8'd24, c); check("t2_pix_24", 32'(c), 0);
        pix_en = 1'b0;

        // five sprites on one line
        put_sprite(0, 8'd49, 8'd10, 8'd0, 8'h02);
        put_sprite(1, 8'd49, 8'd30, 8'd0, 8'h03);
        put_sprite(2, 8'd49, 8'd50, 8'd0, 8'h05);
        put_sprite(3, 8'd49, 8'd70, 8'd0, 8'h07);
        put_sprite(4, 8'd49, 8'd90, 8'd0, 8'h08);
        put_sprite(5, 8'hD0, 8'd0, 8'd0, 8'h00);
        run_line(8'd50, cyc);
        check("t3_busy_done", 32'(busy), 0);
        check("t3_fifth_flag", 32'(fifth_flag), 1);
        check("t3_fifth_num", 32'(fifth_num), 4);
        pixel(8'd10, c); check("t3_pix_s0", 32'(c), 2);
        pixel(8'd30, c); check("t3_pix_s1", 32'(c), 3);
        pixel(8'd50, c); check("t3_pix_s2", 32'(c), 5);
        pixel(8'd77, c); check("t3_pix_s3", 32'(c), 7);
        pixel(8'd90, c); check("t3_pix_s4_hidden", 32'(c), 0);
        check("t3_no_collision", 32'(collision), 0);
        pix_en = 1'b0;
        status_clear = 1'b1;
        step();
        status_clear = 1'b0;
        check("t3_clear_flag", 32'(fifth_flag), 0);
        check("t3_clear_num", 32'(fifth_num), 0);

        // overlap priority and collision
        put_sprite(0, 8'd49, 8'd100, 8'd0, 8'h06);
        put_sprite(1, 8'd49, 8'd100, 8'd0, 8'h09);
        put_sprite(2, 8'hD0, 8'd0, 8'd0, 8'h00);
        run_line(8'd50, cyc);
        check("t4_no_collision_yet", 32'(collision), 0);
        pixel(8'd100, c);
        check("t4_priority", 32'(c), 6);
        check("t4_collision", 32'(collision), 1);
        pix_en = 1'b0;
        status_clear = 1'b1;
        step();
        check("t4_clear_alone", 32'(collision), 0);
        pixel(8'd100, c);
        status_clear = 1'b0;
        check("t4_set_beats_clear", 32'(collision), 1);
        pix_en = 1'b0;
        status_clear = 1'b1;
        step();
        status_clear = 1'b0;

        // 16x16 magnified, early clock, name masked to 4, pattern row 2>>1 = 1
        size16 = 1'b1; mag = 1'b1;
        put_sprite(0, 8'd49, 8'd40, 8'd5, 8'h8C);
        put_sprite(1, 8'hD0, 8'd0, 8'd0, 8'h00);
        vram[PAT + 32 + 1]  = 8'hF0;
        vram[PAT + 32 + 17] = 8'h3C;
        vram[PAT + 32 + 2]  = 8'hFF;
        vram[PAT + 32 + 18] = 8'hFF;
        vram[PAT + 40 + 1]  = 8'hFF;
        run_line(8'd52, cyc);
        check("t5_busy_done", 32'(busy), 0);
        begin
            int xs [10] = '{7, 8, 15, 16, 27, 28, 35, 36, 39, 40};
            int es [10] = '{0, 12, 12, 0, 0, 12, 12, 0, 0, 0};
            for (int i = 0; i < 10; i++) begin
                pixel(8'(xs[i]), c);
                check($sformatf("t5_pix_%0d", xs[i]), 32'(c), 32'(es[i]));
            end
        end
        pix_en = 1'b0;

        // reset in the middle of a scan
        line_y = 8'd52;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        step();
        check("t6_busy_in_scan", 32'(busy), 1);
        reset = 1'b1; pix_en = 1'b1; pix_x = 8'd8;
        step();
        check("t6_reset_busy", 32'(busy), 0);
        check("t6_reset_color", 32'(spr_color), 0);
        reset = 1'b0; pix_en = 1'b0;
        size16 = 1'b0; mag = 1'b0;
        put_sprite(0, 8'd9, 8'd20, 8'd0, 8'h04);
        put_sprite(1, 8'hD0, 8'd0, 8'd0, 8'h00);
        run_line(8'd10, cyc);
        check("t6_restart_busy", 32'(cyc >= 1 && cyc <= 20), 1);
        pixel(8'd24, c); check("t6_pix_24", 32'(c), 4);
        pixel(8'd28, c); check("t6_pix_28", 32'(c), 0);
        pix_en = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Per-scanline sprite processor for the MSX VDP video path, generalising the single hard-wired 8×8 sprite of the current video block. During horizontal blanking it scans the sprite attribute table for the next line. It then fetches attributes and patterns for up to MAX_SPRITES visible sprites and drives a prioritised per-pixel sprite colour to the pixel mixer. It shares the VRAM video read port with the tile fetcher, which is idle during blanking, and reports TMS9918-style 5th-sprite and collision status.

## Interface
- MAX_SPRITES, 4: sprites shown per line (1..8).
- NUM_SPRITES, 32: attribute table entries scanned.
- ADDR_W, 14: VRAM address width.
- clk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- line_start  in  1  one-cycle pulse at start of hblank; begins processing for line `line_y`.
- line_y  in  8  display line to prepare, 0..191.
- sprite_attr_addr, sprite_pattern_table_addr  in  ADDR_W  table bases.
- size16  in  1  16×16 sprites, using 4 consecutive 8×8 patterns.
- mag  in  1  2× magnification.
- vid_addr  out  ADDR_W  VRAM read address.
- vid_out  in  8  VRAM data, valid one cycle after address.
- busy  out  1  fetch in progress; the tile fetcher must not drive the port.
- pix_x  in  8  current display x; valid while pix_en is high.
- pix_en  in  1  active display pixel strobe.
- spr_color  out  4  sprite colour; 0 means transparent.
- fifth_flag  out  1  more than MAX_SPRITES sprites found on a line.
- fifth_num  out  5  index of the first excess sprite.
- collision  out  1  two opaque sprite pixels coincided.
- status_clear  in  1  clears fifth_flag, fifth_num and collision.

## Operation
- FSM states: IDLE → SCAN → ATTR → PAT → LOAD → IDLE.
- **SCAN**: read Y of sprite n at attr+4n.
  - Y = 8'hD0 ends the list and goes to ATTR.
  - row = line_y − Y − 1, computed mod 256. height = 8 << size16 << mag.
  - If row < height, record n and row in the next shadow slot.
  - When slot MAX_SPRITES would be exceeded: if fifth_flag is clear, set it and set fifth_num = n. Then end the scan.
  - The scan also ends after entry NUM_SPRITES−1.
- **ATTR**: per recorded slot, read X (+1), name (+2) and colour/EC (+3).
  - In size16 mode the name is ANDed with 8'hFC.
  - If EC (bit7) is set, effective x = X − 32 (10-bit signed).
- **PAT**: pattern row r = row >> mag.
  - Read byte at pat_base + name×8 + r.
  - In size16 mode also read byte at +16 for the right half.
- **LOAD**: copy shadow slots to active slots in one cycle; unused slots are invalid. Return to IDLE.
- **Pixel**: for each valid active slot, dx = pix_x − effective x. The slot is opaque when 0 ≤ dx < width and the pattern bit at (dx >> mag) is set (MSB first).
  - The lowest-numbered opaque slot with colour ≠ 0 wins.
  - An opaque pixel with colour 0 still counts for collision.
- collision sets when ≥2 slots are opaque on the same pix_en cycle.
- If a status set and status_clear happen in the same cycle, the set wins.
- line_start while busy aborts and restarts SCAN for the new line_y. Active slots are untouched until LOAD.
- Reset: FSM to IDLE, all slots invalid, all status cleared.

## Timing
- Each VRAM read takes 2 cycles: address, then capture.
- Worst case: 2·NUM_SPRITES + MAX_SPRITES·(3+2)·2 + 2 cycles, which is 106 with the defaults. This fits in the 160-cycle hblank.
- busy rises the cycle after line_start and falls the cycle after LOAD.
- spr_color is registered: pix_x/pix_en at cycle N → spr_color at N+1. When pix_en is low, spr_color = 0 at N+1.
- Reset values: vid_addr 0, busy 0, spr_color 0, fifth_flag 0, fifth_num 0, collision 0.

## Structure
- Package msx_vdp_pkg holds:
  - the FSM state enum;
  - SPR_TERMINATOR = 8'hD0;
  - attribute field offsets;
  - the colour-index constants shared with the video mixer.
- Sub-module sprite_slot: holds x, colour and the 16-bit pattern.
  - Inputs: pix_x, mag, size16.
  - Outputs: opaque and colour.
  - It is instantiated MAX_SPRITES times and followed by a priority encoder.

## Test plan
- Sprite 0 at Y=9, X=20, pattern 8'hFF, colour 4; line_y=10 → spr_color=4 for pix_x 20..27 and 0 at 19 and 28. busy is low within 20 cycles.
- Sprite 0 Y=8'hD0 with sprite 1 valid → nothing displayed; busy drops after 4 cycles.
- 5 sprites all on line 50, MAX_SPRITES=4 → sprites 0..3 shown, fifth_flag=1, fifth_num=4. status_clear → both 0.
- Sprites 0 and 1 overlapping at X=100, colours 6 and 9 → spr_color=6 at x=100, collision=1. Then status_clear coinciding with a new overlap → collision stays 1.
- size16=1, mag=1, EC=1, X=40 → 32 pixels wide starting at x=8. Pattern columns double; the right half comes from the +16 byte.
- reset asserted mid-SCAN → next cycle busy=0 and spr_color=0. A later line_start completes normally.
